db9_md_pad_scanner: RTL and testbench
=====================================

// Module: db9_md_pad_scanner
// PURPOSE
//  Scans two Sega Mega Drive pads (3- or 6-button) on the shared DB9 SNAC user port.
//  Drives the pad select line (joy_mdsel) and the port-split line (joy_split), and samples the six shared input lines.
//  Presents two debounced, active-high 16-bit button words to the core top level.
//  The top level muxes these words with the USB joysticks; this block sits directly upstream of that mux.
// PARAMETERS
//  PHASE_CYC  192    clk_sys cycles per select phase (4 us at 48 MHz); input sampled on the last cycle of the phase
//  FRAME_CYC  96000  clk_sys cycles per full scan frame (2 ms); must be >= 16*PHASE_CYC + 1.5 ms idle
// PORTS
//  clk_sys    in   1   system clock; single clock domain
//  reset      in   1   synchronous, active-high reset
//  joy_in     in   6   active-low pad lines: [0]Up [1]Down [2]Left [3]Right [4]B/A [5]C/Start
//  joy_mdsel  out  1   pad select line; idles high
//  joy_split  out  1   0 = port 1 routed to joy_in, 1 = port 2 routed to joy_in
//  joystick1  out  16  port 1 buttons, active-high; layout below
//  joystick2  out  16  port 2 buttons, same layout
//  six_btn    out  2   [0] = port 1 pad detected as 6-button, [1] = port 2
// BEHAVIOUR
//  Button word layout: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start [8]Mode [9]X [10]Y [11]Z; [15:12] = 0.
//  Reset values: joy_mdsel=1, joy_split=0, joystick1=joystick2=0, six_btn=0; frame counter=0; phase=P0.
//  A reset asserted mid-scan aborts the scan on the next edge. Outputs clear and the scan restarts at port 1 P0.
//  Frame sequence: port 1 phases P0..P7, then port 2 phases P0..P7, then IDLE until FRAME_CYC expires.
//  The frame counter wraps at FRAME_CYC-1 to 0 and starts a new frame.
//  joy_split changes only at the start of a port's P0. joy_mdsel changes only at phase boundaries.
//  joy_mdsel per phase is 1 in P0, P2, P4, P6 and 0 in P1, P3, P5, P7; it is 1 in IDLE.
//  Samples taken at the end of each phase (all values inverted):
//   P0  U D L R B C
//   P1  A = joy_in[4], Start = joy_in[5]
//   P5  six = (joy_in[3:0] == 4'b0000)
//   P6  only if six: Z = joy_in[0], Y = joy_in[1], X = joy_in[2], Mode = joy_in[3]
//   P2, P3, P4 and P7 samples are discarded.
//  If six=0, bits [11:8] of the port word are forced to 0.
//  Per-port shadow register; the port word and its six_btn bit update atomically one cycle after that port's P7 sample.
//  No partial-frame values are ever visible on the outputs.
//  Absent pad (pull-ups, joy_in=6'h3F): word=0, six=0. No special-case state is needed.
//  Counter widths: $clog2(PHASE_CYC) and $clog2(FRAME_CYC). Compare with ==, never >=.
// CONFIGURATION
//  DB9_DEBOUNCE_EN
//   defined:  a port word is published only when two consecutive frames produce identical shadow words.
//             Otherwise the old value is held. Added latency: one frame. six_btn is published under the same rule.
//   undefined: the port word is published every frame, with no comparison register.
// STRUCTURE
//  Package db9_pkg:
//   bit-index localparams (DB9_R..DB9_Z)
//   phase_t enum {P0..P7, IDLE}
//   port-word typedef logic [15:0]
//  Sub-module db9_phase_timer:
//   owns the phase and frame counters
//   emits phase_t, the current port index, and a one-cycle sample strobe
//   the top holds the sampling, shadow and debounce logic
// TESTING
//  Cycle counts below use PHASE_CYC=4 and FRAME_CYC=200 for simulation speed.
//  1. Reset, then release: joy_mdsel=1, joy_split=0, outputs 0 -> first mdsel fall at cycle 4; joy_split rises at cycle 32.
//  2. 3-button model on port 1, A+Start held -> joystick1=16'h00C0, joystick2=0, six_btn=2'b00 after frame 1 (frame 2 with DEBOUNCE).
//  3. 6-button model on port 2, X+Mode+Right -> joystick2=16'h0301, six_btn=2'b10; a 3-button pad keeps [11:8]=0.
//  4. Reset pulsed during port 1 P4 -> next edge: mdsel=1, split=0, words=0; the scan restarts at P0 with no glitch pulse.
//  5. DB9_DEBOUNCE_EN, Up held for a single frame only -> joystick1 stays 0; Up held for 2 frames -> 16'h0008.
//  6. Check frame wrap: P0 of consecutive frames starts exactly 200 cycles apart; the idle time is long enough for the 6-button counter to reset.

Source files
------------

// File: rtl/db9_pkg.sv
// Shared types for the Mega Drive DB9 pad scanner: button bit positions,
// scan phase encoding and the published port word type.
package db9_pkg;

    localparam int DB9_PORTS = 2;

    // Bit positions inside the published 16-bit port word
    localparam int DB9_R     = 0;
    localparam int DB9_L     = 1;
    localparam int DB9_D     = 2;
    localparam int DB9_U     = 3;
    localparam int DB9_B     = 4;
    localparam int DB9_C     = 5;
    localparam int DB9_A     = 6;
    localparam int DB9_START = 7;
    localparam int DB9_MODE  = 8;
    localparam int DB9_X     = 9;
    localparam int DB9_Y     = 10;
    localparam int DB9_Z     = 11;

    typedef enum logic [3:0] {
        P0   = 4'd0,
        P1   = 4'd1,
        P2   = 4'd2,
        P3   = 4'd3,
        P4   = 4'd4,
        P5   = 4'd5,
        P6   = 4'd6,
        P7   = 4'd7,
        IDLE = 4'd8
    } phase_t;

    typedef logic [15:0] port_word_t;

    // Select is high on even phases and while idle, low on odd phases
    function automatic logic phase_mdsel(input phase_t ph);
        case (ph)
            P1, P3, P5, P7: return 1'b0;
            default:        return 1'b1;
        endcase
    endfunction

    function automatic phase_t phase_succ(input phase_t ph);
        case (ph)
            P0:      return P1;
            P1:      return P2;
            P2:      return P3;
            P3:      return P4;
            P4:      return P5;
            P5:      return P6;
            P6:      return P7;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/db9_phase_timer.sv
// Scan sequencer: walks port 1 P0..P7, port 2 P0..P7, then idles until the
// frame counter wraps. Select and split lines come straight from registers.
module db9_phase_timer
    import db9_pkg::*;
#(
    parameter int PHASE_CYC = 192,
    parameter int FRAME_CYC = 96000
) (
    input  logic   clk_sys,
    input  logic   reset,
    output phase_t phase,
    output logic   port_idx,
    output logic   sample_stb,
    output logic   mdsel,
    output logic   split
);

    localparam int PW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam int FW = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYC - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYC - 1);

    logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
    logic [PW-1:0] phase_cnt_reg, phase_cnt_next;
    phase_t        phase_reg, phase_next;
    logic          port_reg, port_next;
    logic          mdsel_reg;
    logic          split_reg;
    logic          phase_end;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            frame_cnt_reg <= '0;
            phase_cnt_reg <= '0;
            phase_reg     <= P0;
            port_reg      <= 1'b0;
            mdsel_reg     <= 1'b1;
            split_reg     <= 1'b0;
        end else begin
            frame_cnt_reg <= frame_cnt_next;
            phase_cnt_reg <= phase_cnt_next;
            phase_reg     <= phase_next;
            port_reg      <= port_next;
            // Registered from next-state so the pad lines never see decode glitches
            mdsel_reg     <= phase_mdsel(phase_next);
            split_reg     <= port_next;
        end
    end

    always_comb begin
        frame_cnt_next = frame_cnt_reg + 1'b1;
        phase_cnt_next = phase_cnt_reg;
        phase_next     = phase_reg;
        port_next      = port_reg;
        phase_end      = (phase_reg != IDLE) && (phase_cnt_reg == PHASE_LAST);

        if (frame_cnt_reg == FRAME_LAST) begin
            frame_cnt_next = '0;
            phase_cnt_next = '0;
            phase_next     = P0;
            port_next      = 1'b0;
        end else if (phase_reg != IDLE) begin
            if (phase_end) begin
                phase_cnt_next = '0;
                if (phase_reg == P7) begin
                    if (port_reg) begin
                        phase_next = IDLE;
                    end else begin
                        phase_next = P0;
                        port_next  = 1'b1;
                    end
                end else begin
                    phase_next = phase_succ(phase_reg);
                end
            end else begin
                phase_cnt_next = phase_cnt_reg + 1'b1;
            end
        end
    end

    assign phase      = phase_reg;
    assign port_idx   = port_reg;
    assign sample_stb = phase_end;
    assign mdsel      = mdsel_reg;
    assign split      = split_reg;

endmodule

// File: rtl/db9_md_pad_scanner.sv
// Two-port Mega Drive 3/6-button pad scanner on the shared DB9 lines.
// Optional DB9_DEBOUNCE_EN: publish a port only after two identical frames.
module db9_md_pad_scanner
    import db9_pkg::*;
#(
    parameter int PHASE_CYC = 192,
    parameter int FRAME_CYC = 96000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [5:0]  joy_in,
    output logic        joy_mdsel,
    output logic        joy_split,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic [1:0]  six_btn
);

    phase_t           phase;
    logic             port_idx;
    logic             sample_stb;
    logic [5:0]       joy_n;
    port_word_t       p0_word;
    logic             publish_reg;
    logic             publish_port_reg;
    logic [1:0][15:0] word_bus;
    logic [1:0]       six_bus;

    db9_phase_timer #(
        .PHASE_CYC (PHASE_CYC),
        .FRAME_CYC (FRAME_CYC)
    ) u_timer (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .phase      (phase),
        .port_idx   (port_idx),
        .sample_stb (sample_stb),
        .mdsel      (joy_mdsel),
        .split      (joy_split)
    );

    assign joy_n = ~joy_in;

    // P0 starts a fresh shadow word; later phases only add bits to it
    always_comb begin
        p0_word        = '0;
        p0_word[DB9_U] = joy_n[0];
        p0_word[DB9_D] = joy_n[1];
        p0_word[DB9_L] = joy_n[2];
        p0_word[DB9_R] = joy_n[3];
        p0_word[DB9_B] = joy_n[4];
        p0_word[DB9_C] = joy_n[5];
    end

    // Publish one cycle after the P7 sample of the port just scanned
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            publish_reg      <= 1'b0;
            publish_port_reg <= 1'b0;
        end else begin
            publish_reg      <= sample_stb && (phase == P7);
            publish_port_reg <= port_idx;
        end
    end

    generate
        for (genvar gi = 0; gi < DB9_PORTS; gi++) begin : g_port
            port_word_t shadow_reg;
            port_word_t word_reg;
            logic       six_reg;
            logic       six_pub_reg;
            logic       sample_here;
            logic       publish_here;

            assign sample_here  = sample_stb && (port_idx == 1'(gi));
            assign publish_here = publish_reg && (publish_port_reg == 1'(gi));

            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    shadow_reg <= '0;
                    six_reg    <= 1'b0;
                end else if (sample_here) begin
                    case (phase)
                        P0: shadow_reg <= p0_word;
                        P1: begin
                            shadow_reg[DB9_A]     <= joy_n[4];
                            shadow_reg[DB9_START] <= joy_n[5];
                        end
                        P5: six_reg <= (joy_in[3:0] == 4'b0000);
                        P6: begin
                            // Without a 6-button ack the extra bits stay cleared from P0
                            if (six_reg) begin
                                shadow_reg[DB9_Z]    <= joy_n[0];
                                shadow_reg[DB9_Y]    <= joy_n[1];
                                shadow_reg[DB9_X]    <= joy_n[2];
                                shadow_reg[DB9_MODE] <= joy_n[3];
                            end
                        end
                        default: ;
                    endcase
                end
            end

`ifdef DB9_DEBOUNCE_EN
            port_word_t prev_reg;
            logic       prev_six_reg;

            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    prev_reg     <= '0;
                    prev_six_reg <= 1'b0;
                    word_reg     <= '0;
                    six_pub_reg  <= 1'b0;
                end else if (publish_here) begin
                    prev_reg     <= shadow_reg;
                    prev_six_reg <= six_reg;
                    if ((shadow_reg == prev_reg) && (six_reg == prev_six_reg)) begin
                        word_reg    <= shadow_reg;
                        six_pub_reg <= six_reg;
                    end
                end
            end
`else
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    word_reg    <= '0;
                    six_pub_reg <= 1'b0;
                end else if (publish_here) begin
                    word_reg    <= shadow_reg;
                    six_pub_reg <= six_reg;
                end
            end
`endif

            assign word_bus[gi] = word_reg;
            assign six_bus[gi]  = six_pub_reg;
        end
    endgenerate

    assign joystick1 = word_bus[0];
    assign joystick2 = word_bus[1];
    assign six_btn   = six_bus;

endmodule

// File: tb/tb_db9_md_pad_scanner.sv
// Bench for db9_md_pad_scanner: behavioural 3/6-button pad models on both
// ports, a frame-level publish model, and per-cycle line/word checks.
module tb_db9_md_pad_scanner;

    localparam int PH = 4;
    localparam int FR = 200;
    localparam int PAD_TIMEOUT = 50;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [5:0]  joy_in;
    logic        joy_mdsel;
    logic        joy_split;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic [1:0]  six_btn;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // pad_type: 0 = absent, 1 = 3-button, 2 = 6-button
    int          pad_type[2]     = '{0, 0};
    logic [11:0] pad_btn[2]      = '{12'h0, 12'h0};
    int          pad_cnt[2]      = '{0, 0};
    int          pad_quiet[2]    = '{0, 0};
    logic        pad_sel_prev[2] = '{1'b1, 1'b1};

    // Published model state, bit 16 carries the six-button flag
    logic [16:0] pub[2]  = '{17'h0, 17'h0};
    logic [16:0] prev[2] = '{17'h0, 17'h0};

    always #5 clk_sys = ~clk_sys;

    db9_md_pad_scanner #(
        .PHASE_CYC (PH),
        .FRAME_CYC (FR)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .joy_in    (joy_in),
        .joy_mdsel (joy_mdsel),
        .joy_split (joy_split),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .six_btn   (six_btn)
    );

    // Line levels a real pad presents for a given select level and internal step
    function automatic logic [5:0] pad_lines(input int typ, input logic [11:0] b,
                                             input int cnt, input logic sel);
        logic [5:0] pr;
        if (typ == 0) return 6'h3F;
        if (sel) pr = {b[5], b[4], b[0], b[1], b[2], b[3]};
        else     pr = {b[7], b[6], 1'b1, 1'b1, b[2], b[3]};
        if (typ == 2) begin
            if (cnt == 5)      pr[3:0] = 4'hF;
            else if (cnt == 6) pr[3:0] = {b[8], b[9], b[10], b[11]};
            else if (cnt == 7) pr[3:0] = 4'h0;
        end
        return ~pr;
    endfunction

    always_comb begin
        if (joy_split)
            joy_in = pad_lines(pad_type[1], pad_btn[1], pad_cnt[1], joy_mdsel);
        else
            joy_in = pad_lines(pad_type[0], pad_btn[0], pad_cnt[0], joy_mdsel);
    end

    // Pad-internal step counter: counts select edges, clears after a quiet gap
    always @(negedge clk_sys) begin
        for (int p = 0; p < 2; p++) begin
            logic s;
            s = (int'(joy_split) == p) ? joy_mdsel : 1'b1;
            if (s != pad_sel_prev[p]) begin
                pad_cnt[p]   = pad_cnt[p] + 1;
                pad_quiet[p] = 0;
            end else if (pad_quiet[p] < PAD_TIMEOUT) begin
                pad_quiet[p] = pad_quiet[p] + 1;
            end else begin
                pad_cnt[p] = 0;
            end
            pad_sel_prev[p] = s;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] frame_value(input int typ, input logic [11:0] b);
        if (typ == 0) return 17'h0;
        if (typ == 1) return {1'b0, 8'h00, b[7:0]};
        return {1'b1, 4'h0, b};
    endfunction

    task automatic check_reset_values();
        check("rst_mdsel", 32'(joy_mdsel), 32'd1);
        check("rst_split", 32'(joy_split), 32'd0);
        check("rst_joy1", 32'(joystick1), 32'd0);
        check("rst_joy2", 32'(joystick2), 32'd0);
        check("rst_six", 32'(six_btn), 32'd0);
    endtask

    // Runs one frame from P0 with per-cycle checks; abort_at >= 0 pulses reset there
    task automatic run_frame(input int abort_at);
        logic [16:0] old_pub[2];
        logic [16:0] new_pub[2];
        logic [16:0] sh;
        logic        e_mdsel;
        logic        e_split;
        logic [16:0] e1;
        logic [16:0] e2;
        for (int p = 0; p < 2; p++) begin
            sh         = frame_value(pad_type[p], pad_btn[p]);
            old_pub[p] = pub[p];
`ifdef DB9_DEBOUNCE_EN
            new_pub[p] = (sh == prev[p]) ? sh : pub[p];
            prev[p]    = sh;
`else
            new_pub[p] = sh;
`endif
            pub[p] = new_pub[p];
        end
        for (int pos = 0; pos < FR; pos++) begin
            e_mdsel = (pos < 16 * PH) ? (((pos / PH) % 2) == 0) : 1'b1;
            e_split = (pos >= 8 * PH);
            e1 = (pos >= 8 * PH + 1)  ? new_pub[0] : old_pub[0];
            e2 = (pos >= 16 * PH + 1) ? new_pub[1] : old_pub[1];
            check("mdsel", 32'(joy_mdsel), 32'(e_mdsel));
            check("split", 32'(joy_split), 32'(e_split));
            check("joy1", 32'(joystick1), 32'(e1[15:0]));
            check("joy2", 32'(joystick2), 32'(e2[15:0]));
            check("six", 32'(six_btn), {30'd0, e2[16], e1[16]});
            if (pos == abort_at) begin
                reset = 1'b1;
                @(negedge clk_sys);
                check_reset_values();
                reset = 1'b0;
                pub  = '{17'h0, 17'h0};
                prev = '{17'h0, 17'h0};
                return;
            end
            @(negedge clk_sys);
        end
    endtask

    task automatic set_pad(input int p, input int typ, input logic [11:0] b);
        pad_type[p] = typ;
        pad_btn[p]  = b;
    endtask

    initial begin
        int          hold;
        logic [11:0] b;

        // Reset held: lines idle, words clear
        repeat (3) begin
            @(negedge clk_sys);
            check_reset_values();
        end
        reset = 1'b0;
        run_frame(-1);

        // 3-button pad on port 1, A+Start
        set_pad(0, 1, 12'h0C0);
        run_frame(-1);
        run_frame(-1);
        check("t2_joy1", 32'(joystick1), 32'h00C0);
        check("t2_joy2", 32'(joystick2), 32'h0000);
        check("t2_six", 32'(six_btn), 32'd0);

        // 6-button pad on port 2; 3-button pad on port 1 cannot report X/Mode
        set_pad(0, 1, 12'h3C0);
        set_pad(1, 2, 12'h301);
        run_frame(-1);
        run_frame(-1);
        check("t3_joy2", 32'(joystick2), 32'h0301);
        check("t3_six", 32'(six_btn), 32'd2);
        check("t3_joy1", 32'(joystick1), 32'h00C0);

        // Reset during port 1 P4, then the scan restarts cleanly
        run_frame(4 * PH + 1);
        run_frame(-1);
        run_frame(-1);
        check("t4_joy1", 32'(joystick1), 32'h00C0);
        check("t4_joy2", 32'(joystick2), 32'h0301);

        // Up for a single frame, then for two
        set_pad(0, 1, 12'h000);
        run_frame(-1);
        run_frame(-1);
        set_pad(0, 1, 12'h008);
        run_frame(-1);
`ifdef DB9_DEBOUNCE_EN
        check("t5_single", 32'(joystick1), 32'h0000);
`else
        check("t5_single", 32'(joystick1), 32'h0008);
`endif
        set_pad(0, 1, 12'h000);
        run_frame(-1);
        check("t5_release", 32'(joystick1), 32'h0000);
        set_pad(0, 1, 12'h008);
        run_frame(-1);
        run_frame(-1);
        check("t5_double", 32'(joystick1), 32'h0008);

        // Randomised pads and buttons, each held for 1-3 frames
        for (int g = 0; g < 8; g++) begin
            for (int p = 0; p < 2; p++) begin
                b = 12'($urandom);
                if (b[3] && b[2]) b[2] = 1'b0;
                set_pad(p, int'($urandom_range(0, 2)), b);
            end
            hold = int'($urandom_range(1, 3));
            for (int f = 0; f < hold; f++) run_frame(-1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
